// File: rtl/wb_mtimer_pkg.sv
// Shared definitions for the Wishbone machine timer: register indices,
// CTRL/STATUS bit positions and byte-lane helpers.
package wb_mtimer_pkg;

  // Register index = word address bits [4:2]
  localparam logic [2:0] REG_MTIME_LO = 3'd0;
  localparam logic [2:0] REG_MTIME_HI = 3'd1;
  localparam logic [2:0] REG_CMP_LO   = 3'd2;
  localparam logic [2:0] REG_CMP_HI   = 3'd3;
  localparam logic [2:0] REG_CTRL     = 3'd4;
  localparam logic [2:0] REG_STATUS   = 3'd5;

  // CTRL / STATUS field positions
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_DIV_LSB   = 8;
  localparam int STATUS_IRQ_BIT = 0;

  // Read data returned alongside an error pulse
  localparam logic [31:0] ERR_RDT = 32'h0;

  // Expand byte enables into a 32-bit bit mask
  function automatic logic [31:0] sel_mask(input logic [3:0] sel);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{sel[i]}};
    end
    return m;
  endfunction

  // Replace only the enabled bytes of old_val with new_val
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    logic [31:0] m;
    m = sel_mask(sel);
    return (old_val & ~m) | (new_val & m);
  endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Prescaler for the machine timer: emits one tick every (div+1) enabled
// clocks. The count restarts from zero when disabled or when div is rewritten.
module mtimer_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] div,
  input  logic                  wr_div,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] count;

  assign tick = en && (count == div);

  // Count enabled clocks; wrap on tick, clear on disable or divider rewrite
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
    end else if (!en || wr_div || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/wb_mtimer.sv
// Wishbone classic slave holding a 64-bit mtime/mtimecmp pair, a prescaler
// and a registered level interrupt. Reading MTIME_LO snapshots the upper
// half into a shadow so a following MTIME_HI read forms a coherent pair.
module wb_mtimer
  import wb_mtimer_pkg::*;
#(
  parameter int          PRESCALE_W = 8,
  parameter logic [63:0] CMP_RST    = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [9:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_wb_err,
  output logic        o_irq
);

  // Handshake: a request is cyc & stb while no ack/err pulse is out. Each
  // request is answered on the next clock by exactly one single-cycle pulse,
  // ack for mapped offsets or err for unmapped ones, so a master holding stb
  // gets one transfer every two clocks. Writes commit on the request edge.

  logic [63:0]           mtime;
  logic [63:0]           cmp;
  logic [31:0]           shadow;
  logic                  en;
  logic [PRESCALE_W-1:0] div;
  logic                  tick;

  logic                  req;
  logic                  mapped;
  logic [2:0]            reg_idx;
  logic                  wr;
  logic                  rd;
  logic                  wr_div;
  logic                  en_new;
  logic [PRESCALE_W-1:0] div_new;
  logic                  div_hit;
  logic [31:0]           ctrl_q;
  logic [31:0]           rd_data;

  assign reg_idx = i_wb_adr[2:0];
  assign req     = i_wb_cyc && i_wb_stb && !o_wb_ack && !o_wb_err;
  assign mapped  = (i_wb_adr[9:3] == 7'd0) && (reg_idx <= REG_STATUS);
  assign wr      = req && mapped && i_wb_we;
  assign rd      = req && mapped && !i_wb_we;
  assign wr_div  = wr && (reg_idx == REG_CTRL) && div_hit;
  assign en_new  = i_wb_sel[CTRL_EN_BIT/8] ? i_wb_dat[CTRL_EN_BIT] : en;

  mtimer_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .en     (en),
    .div    (div),
    .wr_div (wr_div),
    .tick   (tick)
  );

  // Byte-lane merge of the divide field; div_hit flags any div byte written
  always_comb begin
    div_new = div;
    div_hit = 1'b0;
    for (int j = 0; j < PRESCALE_W; j++) begin
      if (i_wb_sel[(CTRL_DIV_LSB + j) / 8]) begin
        div_new[j] = i_wb_dat[CTRL_DIV_LSB + j];
        div_hit    = 1'b1;
      end
    end
  end

  // CTRL register image as seen on the bus
  always_comb begin
    ctrl_q                               = '0;
    ctrl_q[CTRL_EN_BIT]                  = en;
    ctrl_q[CTRL_DIV_LSB +: PRESCALE_W]   = div;
  end

  // Read data mux
  always_comb begin
    rd_data = ERR_RDT;
    case (reg_idx)
      REG_MTIME_LO: rd_data = mtime[31:0];
      REG_MTIME_HI: rd_data = shadow;
      REG_CMP_LO:   rd_data = cmp[31:0];
      REG_CMP_HI:   rd_data = cmp[63:32];
      REG_CTRL:     rd_data = ctrl_q;
      REG_STATUS: begin
        rd_data                 = '0;
        rd_data[STATUS_IRQ_BIT] = o_irq;
      end
      default:      rd_data = ERR_RDT;
    endcase
  end

  // Bus response: single-cycle ack or err with registered read data
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;
      o_wb_rdt <= '0;
    end else if (req && mapped) begin
      o_wb_ack <= 1'b1;
      o_wb_err <= 1'b0;
      o_wb_rdt <= i_wb_we ? 32'h0 : rd_data;
    end else if (req) begin
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b1;
      o_wb_rdt <= ERR_RDT;
    end else begin
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;
      o_wb_rdt <= '0;
    end
  end

  // mtime: a bus write to either half wins over a tick on the same edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mtime <= '0;
    end else if (wr && (reg_idx == REG_MTIME_LO)) begin
      mtime[31:0] <= byte_merge(mtime[31:0], i_wb_dat, i_wb_sel);
    end else if (wr && (reg_idx == REG_MTIME_HI)) begin
      mtime[63:32] <= byte_merge(mtime[63:32], i_wb_dat, i_wb_sel);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  // Shadow captures the upper half on every MTIME_LO read
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shadow <= '0;
    end else if (rd && (reg_idx == REG_MTIME_LO)) begin
      shadow <= mtime[63:32];
    end
  end

  // Compare register writes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cmp <= CMP_RST;
    end else if (wr && (reg_idx == REG_CMP_LO)) begin
      cmp[31:0] <= byte_merge(cmp[31:0], i_wb_dat, i_wb_sel);
    end else if (wr && (reg_idx == REG_CMP_HI)) begin
      cmp[63:32] <= byte_merge(cmp[63:32], i_wb_dat, i_wb_sel);
    end
  end

  // CTRL register writes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      en  <= 1'b0;
      div <= '0;
    end else if (wr && (reg_idx == REG_CTRL)) begin
      en  <= en_new;
      div <= div_new;
    end
  end

  // Level interrupt, one clock behind any mtime/cmp change
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_irq <= 1'b0;
    end else begin
      o_irq <= (mtime >= cmp);
    end
  end

endmodule

// File: tb/tb_wb_mtimer.sv
// Directed bench for wb_mtimer: bus tasks drive one access every two clocks,
// outputs are sampled on the falling edge, expectations are hand-computed.
module tb_wb_mtimer;
  import wb_mtimer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  adr = '0;
  logic [31:0] dat = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic [31:0] rdt;
  logic        ack;
  logic        err;
  logic        irq;

  int          checks = 0;
  int          passed = 0;
  logic [31:0] exp_q[$];

  // Clock
  always #5 clk = ~clk;

  wb_mtimer dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_wb_adr(adr),
    .i_wb_dat(dat),
    .i_wb_sel(sel),
    .i_wb_we (we),
    .i_wb_cyc(cyc),
    .i_wb_stb(stb),
    .o_wb_rdt(rdt),
    .o_wb_ack(ack),
    .o_wb_err(err),
    .o_irq   (irq)
  );

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One access: drive on a falling edge, sample the response one clock later
  task automatic bus(input logic w, input logic [9:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] r,
                     output logic k, output logic e);
    @(negedge clk);
    check("idle_flags", {ack, err}, 64'd0);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    @(negedge clk);
    r = rdt; k = ack; e = err;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    logic k, e;
    bus(1'b1, a, d, s, r, k, e);
    check("wr_ack", {k, e}, 64'h2);
  endtask

  task automatic rd(input logic [9:0] a, output logic [31:0] r);
    logic k, e;
    bus(1'b0, a, 32'h0, 4'hF, r, k, e);
    check("rd_ack", {k, e}, 64'h2);
  endtask

  task automatic rd_chk(input string tag, input logic [9:0] a, input logic [31:0] exp);
    logic [31:0] r;
    rd(a, r);
    check(tag, r, exp);
  endtask

  initial begin
    logic [31:0] r;
    logic k, e;
    logic [3:0] pat;

    // 1. Reset state and post-reset register reads
    #1;
    check("rst_outputs", {ack, err, irq, rdt}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rd_chk("rst_mtime_lo", 10'd0, 32'h0);
    rd_chk("rst_mtime_hi", 10'd1, 32'h0);
    rd_chk("rst_cmp_lo",   10'd2, 32'hFFFF_FFFF);
    rd_chk("rst_cmp_hi",   10'd3, 32'hFFFF_FFFF);
    rd_chk("rst_ctrl",     10'd4, 32'h0);
    rd_chk("rst_status",   10'd5, 32'h0);

    // Held strobe: ack pattern 1,0,1,0
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 10'd4; sel = 4'hF;
    pat = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b_ack", ack, pat[i]);
    end
    cyc = 1'b0; stb = 1'b0;

    // 2. Coherent read across the 32-bit carry
    wr(10'd0, 32'hFFFF_FFFE, 4'hF);
    wr(10'd1, 32'h0, 4'hF);
    wr(10'd4, 32'h1, 4'hF);
    rd_chk("pair1_lo", 10'd0, 32'hFFFF_FFFF);
    rd_chk("pair1_hi", 10'd1, 32'h0);
    rd_chk("pair2_lo", 10'd0, 32'h3);
    rd_chk("pair2_hi", 10'd1, 32'h1);

    // 3. div=3, freeze on disable, count restart on re-enable
    wr(10'd4, 32'h0, 4'hF);
    wr(10'd0, 32'h0, 4'hF);
    wr(10'd1, 32'h0, 4'hF);
    wr(10'd4, 32'h301, 4'hF);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_q.push_back(32'd1); exp_q.push_back(32'd1);
    for (int i = 0; i < 4; i++) begin
      rd(10'd0, r);
      check("div3_count", r, exp_q.pop_front());
    end
    wr(10'd4, 32'h300, 4'hF);
    exp_q.push_back(32'd2); exp_q.push_back(32'd2);
    for (int i = 0; i < 2; i++) begin
      rd(10'd0, r);
      check("frozen", r, exp_q.pop_front());
    end
    wr(10'd4, 32'h1, 4'b0001);
    exp_q.push_back(32'd2); exp_q.push_back(32'd2); exp_q.push_back(32'd3);
    for (int i = 0; i < 3; i++) begin
      rd(10'd0, r);
      check("restart", r, exp_q.pop_front());
    end
    rd_chk("ctrl_div_kept", 10'd4, 32'h301);

    // 4. Interrupt timing
    wr(10'd4, 32'h0, 4'hF);
    wr(10'd0, 32'h0, 4'hF);
    wr(10'd1, 32'h0, 4'hF);
    wr(10'd2, 32'd10, 4'hF);
    wr(10'd3, 32'h0, 4'hF);
    check("irq_idle", irq, 1'b0);
    wr(10'd4, 32'h1, 4'hF);
    repeat (10) @(negedge clk);
    check("irq_before", irq, 1'b0);
    @(negedge clk);
    check("irq_rise", irq, 1'b1);
    rd_chk("status_irq", 10'd5, 32'h1);
    wr(10'd2, 32'hFFFF_FFFF, 4'hF);
    check("irq_at_ack", irq, 1'b1);
    @(negedge clk);
    check("irq_cleared", irq, 1'b0);

    // 5. Unmapped accesses and byte lanes
    wr(10'd4, 32'h0, 4'hF);
    wr(10'd0, 32'h55, 4'hF);
    wr(10'd1, 32'h0, 4'hF);
    bus(1'b0, 10'd6, 32'h0, 4'hF, r, k, e);
    check("err18_flags", {k, e}, 64'h1);
    check("err18_rdt", r, 32'h0);
    bus(1'b1, 10'd7, 32'hDEAD_BEEF, 4'hF, r, k, e);
    check("err1c_flags", {k, e}, 64'h1);
    bus(1'b1, 10'h008, 32'h1234_5678, 4'hF, r, k, e);
    check("err_hi_wr_flags", {k, e}, 64'h1);
    bus(1'b0, 10'h008, 32'h0, 4'hF, r, k, e);
    check("err_hi_rd_flags", {k, e}, 64'h1);
    check("err_hi_rdt", r, 32'h0);
    rd_chk("alias_nochange", 10'd0, 32'h55);
    wr(10'd2, 32'h0000_AB00, 4'b0010);
    rd_chk("cmp_lo_byte1", 10'd2, 32'hFFFF_ABFF);
    rd_chk("cmp_hi_kept", 10'd3, 32'h0);
    wr(10'd5, 32'hFFFF_FFFF, 4'hF);
    rd_chk("status_ro", 10'd5, 32'h0);

    // 6. Asynchronous reset mid-access
    wr(10'd2, 32'h0, 4'hF);
    rd_chk("status_pre_rst", 10'd5, 32'h1);
    check("irq_pre_rst", irq, 1'b1);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 10'd2; sel = 4'hF;
    #2 rst_n = 1'b0;
    #1 check("async_rst_out", {ack, err, irq, rdt}, 64'd0);
    @(negedge clk);
    check("rst_no_ack", {ack, err}, 64'd0);
    cyc = 1'b0; stb = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_no_ack", {ack, err}, 64'd0);
    rd_chk("post_rst_mtime", 10'd0, 32'h0);
    rd_chk("post_rst_cmp_lo", 10'd2, 32'hFFFF_FFFF);
    rd_chk("post_rst_cmp_hi", 10'd3, 32'hFFFF_FFFF);
    rd_chk("post_rst_ctrl", 10'd4, 32'h0);

    // 64-bit wrap with interrupt following the compare
    wr(10'd0, 32'hFFFF_FFFF, 4'hF);
    wr(10'd1, 32'hFFFF_FFFF, 4'hF);
    wr(10'd4, 32'h1, 4'hF);
    check("wrap_irq_max", irq, 1'b1);
    @(negedge clk);
    check("wrap_irq_hold", irq, 1'b1);
    @(negedge clk);
    check("wrap_irq_low", irq, 1'b0);
    rd_chk("wrap_lo", 10'd0, 32'h2);
    rd_chk("wrap_hi", 10'd1, 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
